// File: rtl/mem_access_if.sv
// Load/store request, response and word-memory bus between the core, the
// mem_access_unit and the data memory.
//   master : mem_access_unit side (drives req_ready, resp_*, mem_* strobes/address/data)
//   slave  : environment side (core drives req_*/resp_ready, memory drives mem_read_data)
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [31:0] mem_address;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    input  resp_ready,
    output mem_address, mem_write_en, mem_read_en, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    output resp_ready,
    input  mem_address, mem_write_en, mem_read_en, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store unit in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and
// sign/zero extended; misaligned, illegal-size and out-of-range requests are
// answered with resp_error and never touch the memory.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_access_if.master (request, response and memory buses)
module mem_access_unit #(
  parameter int unsigned DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.master bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR,
    RESP
  } state_t;

  state_t      state;
  logic        op_write;
  logic [1:0]  op_size;
  logic [1:0]  op_lane;
  logic        op_unsigned;
  logic [31:0] op_wdata;

  logic [31:0] word_index;
  logic        req_err;

  // Right-align the addressed lane and extend it.
  function automatic logic [31:0] load_extract(logic [31:0] word, logic [1:0] size,
                                               logic [1:0] lane, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the read word with the store data.
  function automatic logic [31:0] store_merge(logic [31:0] word, logic [1:0] size,
                                              logic [1:0] lane, logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (size == SIZE_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wdata[15:0];
    end else begin
      r[15:0] = wdata[15:0];
    end
    return r;
  endfunction

  assign word_index = {2'b00, bus.req_addr[31:2]};

  // Request is rejected before any memory traffic.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'b11)                                    req_err = 1'b1;
    if (bus.req_size == SIZE_HALF && bus.req_addr[0])             req_err = 1'b1;
    if (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00)  req_err = 1'b1;
    if (word_index >= DEPTH)                                      req_err = 1'b1;
  end

  assign bus.req_ready = (state == IDLE) && !rst;

  // Control FSM with registered response and memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      op_write           <= 1'b0;
      op_size            <= 2'b00;
      op_lane            <= 2'b00;
      op_unsigned        <= 1'b0;
      op_wdata           <= 32'h0;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= 32'h0;
      bus.resp_error     <= 1'b0;
      bus.mem_address    <= 32'h0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_read_en    <= 1'b0;
      bus.mem_write_data <= 32'h0;
    end else begin
      // Strobes are single-cycle pulses; only the state that owns one raises it.
      bus.mem_write_en <= 1'b0;
      bus.mem_read_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_write    <= bus.req_write;
            op_size     <= bus.req_size;
            op_lane     <= bus.req_addr[1:0];
            op_unsigned <= bus.req_unsigned;
            op_wdata    <= bus.req_wdata;
            bus.resp_rdata <= 32'h0;
            if (req_err) begin
              bus.resp_error <= 1'b1;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else begin
              bus.resp_error  <= 1'b0;
              bus.mem_address <= word_index;
              if (bus.req_write && bus.req_size == SIZE_WORD) begin
                bus.mem_write_data <= bus.req_wdata;
                state              <= WR_SETUP;
              end else begin
                bus.mem_read_en <= 1'b1;
                state           <= RD;
              end
            end
          end
        end
        RD: begin
          if (op_write) begin
            bus.mem_write_data <= store_merge(bus.mem_read_data, op_size, op_lane, op_wdata);
            state              <= WR_SETUP;
          end else begin
            bus.resp_rdata <= load_extract(bus.mem_read_data, op_size, op_lane, op_unsigned);
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        WR_SETUP: begin
          bus.mem_write_en <= 1'b1;
          state            <= WR;
        end
        WR: begin
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural memory.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  mem_access_if bus ();

  mem_access_unit #(.DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural word memory: combinational read, write on strobe.
  logic [31:0] mem [32];
  assign bus.mem_read_data = mem[bus.mem_address[4:0]];
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_address[4:0]] <= bus.mem_write_data;
  end

  // Strobe monitor, sampled mid-cycle.
  int rd_cnt = 0;
  int wr_cnt = 0;
  int overlap_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  always @(negedge clk) begin
    if (bus.mem_read_en) rd_cnt++;
    if (bus.mem_write_en) begin
      wr_cnt++;
      last_waddr = bus.mem_address;
      last_wdata = bus.mem_write_data;
    end
    if (bus.mem_read_en && bus.mem_write_en) overlap_cnt++;
  end

  int checks = 0;
  int errors = 0;

  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_rd;
  int          got_wr;
  logic        post_valid;
  logic        post_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] d);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.req_wdata    = d;
  endtask

  task automatic drop_req();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b1;
    bus.req_addr     = 32'hFFFF_FFFF;
    bus.req_size     = 2'b11;
    bus.req_unsigned = 1'b1;
    bus.req_wdata    = 32'hA5A5_A5A5;
  endtask

  // One full transaction: wait ready, accept, measure latency, handshake.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d);
    int n;
    int rd0;
    int wr0;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_req(w, a, s, u, d);
    @(posedge clk); #1;
    drop_req();
    got_lat = 1;
    while (!bus.resp_valid && got_lat < 20) begin
      @(posedge clk); #1; got_lat++;
    end
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_error;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    post_valid = bus.resp_valid;
    post_ready = bus.req_ready;
    got_rd = rd_cnt - rd0;
    got_wr = wr_cnt - wr0;
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic [31:0] rdata,
                             input logic err, input int nrd, input int nwr);
    check({tag, "_lat"},   32'(got_lat), 32'(lat));
    check({tag, "_rdata"}, got_rdata, rdata);
    check({tag, "_err"},   32'(got_err), 32'(err));
    check({tag, "_rd"},    32'(got_rd), 32'(nrd));
    check({tag, "_wr"},    32'(got_wr), 32'(nwr));
    check({tag, "_done"},  {30'h0, post_valid, post_ready}, 32'h1);
  endtask

  logic [31:0] held_rdata;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1;
    bus.resp_ready = 1'b0;
    drop_req();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  32'(bus.req_ready), 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_strobes",    {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
    check("rst_mem_addr",   bus.mem_address, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);

    // Word store then word load
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
    expect_resp("sw10", 3, 32'h0, 1'b0, 0, 1);
    check("sw10_waddr", last_waddr, 32'd4);
    check("sw10_wdata", last_wdata, 32'hDEAD_BEEF);
    check("sw10_mem",   mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    expect_resp("lw10", 2, 32'hDEAD_BEEF, 1'b0, 1, 0);

    // Byte store into lane 1, loads signed/unsigned
    do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h1234_5680);
    expect_resp("sb11", 4, 32'h0, 1'b0, 1, 1);
    check("sb11_wdata", last_wdata, 32'hDEAD_80EF);
    do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0);
    expect_resp("lb11", 2, 32'hFFFF_FF80, 1'b0, 1, 0);
    do_req(1'b0, 32'h11, 2'b00, 1'b1, 32'h0);
    expect_resp("lbu11", 2, 32'h0000_0080, 1'b0, 1, 0);

    // Half store to upper lane, various loads
    do_req(1'b1, 32'h12, 2'b01, 1'b0, 32'hABCD_1234);
    expect_resp("sh12", 4, 32'h0, 1'b0, 1, 1);
    check("sh12_mem", mem[4], 32'h1234_80EF);
    do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0);
    expect_resp("lh12", 2, 32'h0000_1234, 1'b0, 1, 0);
    do_req(1'b0, 32'h10, 2'b01, 1'b0, 32'h0);
    expect_resp("lh10", 2, 32'hFFFF_80EF, 1'b0, 1, 0);
    do_req(1'b0, 32'h10, 2'b01, 1'b1, 32'h0);
    expect_resp("lhu10", 2, 32'h0000_80EF, 1'b0, 1, 0);
    do_req(1'b0, 32'h10, 2'b10, 1'b1, 32'h0);
    expect_resp("lw10u", 2, 32'h1234_80EF, 1'b0, 1, 0);
    do_req(1'b0, 32'h10, 2'b00, 1'b0, 32'h0);
    expect_resp("lb10", 2, 32'hFFFF_FFEF, 1'b0, 1, 0);
    do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
    expect_resp("lb13", 2, 32'h0000_0012, 1'b0, 1, 0);

    // Highest valid word, byte store lane 3
    do_req(1'b1, 32'h7C, 2'b10, 1'b0, 32'h0102_0304);
    expect_resp("sw7c", 3, 32'h0, 1'b0, 0, 1);
    do_req(1'b1, 32'h7F, 2'b00, 1'b0, 32'h0000_00F0);
    expect_resp("sb7f", 4, 32'h0, 1'b0, 1, 1);
    check("sb7f_mem", mem[31], 32'hF002_0304);

    // Error cases: no strobes, cycle-1 response
    do_req(1'b0, 32'h02, 2'b10, 1'b0, 32'h0);
    expect_resp("err_lw02", 1, 32'h0, 1'b1, 0, 0);
    do_req(1'b0, 32'h03, 2'b01, 1'b0, 32'h0);
    expect_resp("err_lh03", 1, 32'h0, 1'b1, 0, 0);
    do_req(1'b0, 32'h80, 2'b10, 1'b0, 32'h0);
    expect_resp("err_lw80", 1, 32'h0, 1'b1, 0, 0);
    do_req(1'b0, 32'h00, 2'b11, 1'b0, 32'h0);
    expect_resp("err_sz11", 1, 32'h0, 1'b1, 0, 0);
    do_req(1'b1, 32'h80, 2'b10, 1'b0, 32'hFFFF_FFFF);
    expect_resp("err_sw80", 1, 32'h0, 1'b1, 0, 0);
    check("err_sw80_mem0", mem[0], 32'h0);

    // Response back-pressure
    drive_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    @(posedge clk); #1;
    drop_req();
    @(posedge clk); #1;
    held_rdata = bus.resp_rdata;
    check("hold_first_valid", 32'(bus.resp_valid), 32'h1);
    check("hold_first_rdata", held_rdata, 32'h1234_80EF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'h1);
      check("hold_rdata", bus.resp_rdata, held_rdata);
      check("hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("hold_release_valid", 32'(bus.resp_valid), 32'h0);
    check("hold_release_ready", 32'(bus.req_ready), 32'h1);
    do_req(1'b0, 32'h7C, 2'b10, 1'b0, 32'h0);
    expect_resp("b2b_lw7c", 2, 32'hF002_0304, 1'b0, 1, 0);

    // Reset while the read strobe is high
    drive_req(1'b1, 32'h10, 2'b00, 1'b0, 32'h0000_0055);
    @(posedge clk); #1;
    drop_req();
    check("rst_rd_strobe_on", 32'(bus.mem_read_en), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_rd_strobes_off", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
    check("rst_rd_req_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during WR_SETUP of a byte store
    drive_req(1'b1, 32'h10, 2'b00, 1'b0, 32'h0000_0055);
    @(posedge clk); #1;
    drop_req();
    @(posedge clk); #1;
    check("wrs_strobes", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
    check("wrs_wdata", bus.mem_write_data, 32'h1234_8055);
    got_wr = wr_cnt;
    rst = 1'b1;
    #1;
    check("wrs_rst_strobes", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
    check("wrs_rst_valid", 32'(bus.resp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("wrs_release_ready", 32'(bus.req_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("wrs_no_resp", 32'(bus.resp_valid), 32'h0);
    check("wrs_no_write", 32'(wr_cnt - got_wr), 32'h0);
    check("wrs_mem_kept", mem[4], 32'h1234_80EF);

    check("strobe_overlap", 32'(overlap_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
